// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants, stage-control record and hazard-tracker FSM states.
package cpu_pipe_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] ADDR_REG = 4'd10;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rt;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_NOP = '0;

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    MEM_WAIT
  } pipe_state_e;

endpackage

// File: rtl/hazard_track_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_track_unit.sv
// Tracks in-flight destinations through ID/EX, EX/MEM and MEM/WB for the forwarding
// unit, bubbling uncoverable load-use pairs and freezing on unacknowledged memory accesses.
module hazard_track_unit
  import cpu_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             mem_ready,
  output logic             stall_fetch,
  output logic             bubble_idex,
  output logic             freeze,
  output logic [REG_W-1:0] idex_rd,
  output logic [REG_W-1:0] idex_rt,
  output logic             idex_regwrite,
  output logic             idex_memread,
  output logic             idex_memwrite,
  output logic [REG_W-1:0] exmem_rd,
  output logic             exmem_regwrite,
  output logic             exmem_mem,
  output logic [REG_W-1:0] memwb_rd,
  output logic             memwb_regwrite,
  output logic [CNT_W-1:0] load_stalls,
  output logic [CNT_W-1:0] wait_cycles
);

  pipe_state_e      state_q;
  stage_ctl_t       idexStage_q, idexStage_d;
  logic [REG_W-1:0] exmemRd_q, memwbRd_q;
  logic             exmemRegwrite_q, exmemMem_q, memwbRegwrite_q;
  logic             freezeCond, addrUse, srcMatch, hazard;

  assign freezeCond = exmemMem_q & ~mem_ready;
  assign addrUse    = id_memread | id_memwrite;
  assign srcMatch   = (idexStage_q.rd == id_src_a) || (idexStage_q.rd == id_src_b) ||
                      ((idexStage_q.rd == ADDR_REG) && addrUse);

  // Also evaluated in MEM_WAIT so a load-use pair held by the freeze is bubbled on release.
  assign hazard = id_valid && (state_q != LDSTALL) && idexStage_q.memread &&
                  idexStage_q.regwrite && (idexStage_q.rd != '0) && srcMatch;

  assign bubble_idex = hazard & ~freezeCond;
  assign freeze      = freezeCond;
  assign stall_fetch = bubble_idex | freezeCond;

  always_comb begin
    idexStage_d = STAGE_NOP;
    if (id_valid && !bubble_idex) begin
      idexStage_d.rd       = id_regwrite ? id_dest : id_src_a;
      idexStage_d.rt       = id_src_b;
      idexStage_d.regwrite = id_regwrite;
      idexStage_d.memread  = id_memread;
      idexStage_d.memwrite = id_memwrite;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q         <= RUN;
      idexStage_q     <= STAGE_NOP;
      exmemRd_q       <= '0;
      exmemRegwrite_q <= 1'b0;
      exmemMem_q      <= 1'b0;
      memwbRd_q       <= '0;
      memwbRegwrite_q <= 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (freezeCond)  state_q <= MEM_WAIT;
          else if (hazard) state_q <= LDSTALL;
          else             state_q <= RUN;
        end
        LDSTALL: state_q <= freezeCond ? MEM_WAIT : RUN;
        default: state_q <= RUN;
      endcase
      if (!freezeCond) begin
        idexStage_q     <= idexStage_d;
        exmemRd_q       <= idexStage_q.rd;
        exmemRegwrite_q <= idexStage_q.regwrite;
        exmemMem_q      <= idexStage_q.memread | idexStage_q.memwrite;
        memwbRd_q       <= exmemRd_q;
        memwbRegwrite_q <= exmemRegwrite_q;
      end
    end
  end

  assign idex_rd        = idexStage_q.rd;
  assign idex_rt        = idexStage_q.rt;
  assign idex_regwrite  = idexStage_q.regwrite;
  assign idex_memread   = idexStage_q.memread;
  assign idex_memwrite  = idexStage_q.memwrite;
  assign exmem_rd       = exmemRd_q;
  assign exmem_regwrite = exmemRegwrite_q;
  assign exmem_mem      = exmemMem_q;
  assign memwb_rd       = memwbRd_q;
  assign memwb_regwrite = memwbRegwrite_q;

  sat_counter #(.CNT_W(CNT_W)) u_loadStallCnt (
    .clk_i   (clk),
    .rst_i   (rest),
    .inc_i   (bubble_idex),
    .clear_i (1'b0),
    .count_o (load_stalls)
  );

  sat_counter #(.CNT_W(CNT_W)) u_waitCycleCnt (
    .clk_i   (clk),
    .rst_i   (rest),
    .inc_i   (freezeCond),
    .clear_i (1'b0),
    .count_o (wait_cycles)
  );

endmodule
